// File: rtl/adc_capture_pkg.sv
// Shared types and widths for the ADC capture controller.
// Holds the FSM state encoding and the ADC interface word widths.
package adc_capture_pkg;
   localparam int ADC_DATA_W = 10;
   localparam int ADC_CFG_W  = 10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ADC_RST = 2'd1,
      RUN     = 2'd2
   } state_e;
endpackage

// File: rtl/adc_result_fifo.sv
// Synchronous result FIFO: head is the registered entry at rd_ptr, push/pop/level update in one cycle.
// Push is refused when full unless a pop happens in the same cycle; pop is ignored when empty.
module adc_result_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_dat_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_dat_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      level_q, level_d;
   logic             push_ok, pop_ok;

   assign empty_o    = (level_q == '0);
   assign full_o     = (level_q == (AW+1)'(DEPTH));
   assign pop_ok     = pop_i & ~empty_o;
   assign push_ok    = push_i & (~full_o | pop_ok);
   assign head_dat_o = mem_q[rd_ptr_q];
   assign level_o    = level_q;

   always_comb begin
      level_d = level_q;
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
      end
   end
endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: sequences ADC reset/config, syncs the conversion strobe, queues results.
// Strobe sampled at edge k is pushed at edge k+2; consumer stalls via ready, a full FIFO drops and flags overflow.
module adc_capture_ctrl
   import adc_capture_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int RST_CYCLES = 16,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start_in,
   input  logic                          stop_in,
   input  logic [CNT_W-1:0]              burst_len_in,
   input  logic [ADC_CFG_W-1:0]          cfg_1_in,
   input  logic [ADC_CFG_W-1:0]          cfg_2_in,
   input  logic                          adc_conv_finished_in,
   input  logic [ADC_DATA_W-1:0]         adc_result_in,
   output logic                          adc_rst_n_out,
   output logic [ADC_CFG_W-1:0]          adc_config_1_out,
   output logic [ADC_CFG_W-1:0]          adc_config_2_out,
   output logic [ADC_DATA_W-1:0]         data_out,
   output logic                          data_valid_out,
   input  logic                          data_ready_in,
   output logic                          busy_out,
   output logic                          overflow_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out
);
   localparam int RC_W = $clog2(RST_CYCLES) + 1;

   state_e                 state_q, state_d;
   logic [RC_W-1:0]        rcnt_q, rcnt_d;
   logic [CNT_W-1:0]       scnt_q, scnt_d, scnt_inc;
   logic [CNT_W-1:0]       burst_q, burst_d;
   logic [ADC_CFG_W-1:0]   cfg1_q, cfg1_d, cfg2_q, cfg2_d;
   logic                   ovf_q, ovf_d;
   logic [2:0]             sync_q;
   logic                   strobe_edge, push, pop, flush, drop, fifo_full, fifo_empty;

   assign strobe_edge = sync_q[1] & ~sync_q[2];
   assign push        = strobe_edge & (state_q == RUN);
   assign pop         = data_valid_out & data_ready_in;
   assign drop        = push & fifo_full & ~pop;
   // Counter holds at all-ones so continuous runs never wrap.
   assign scnt_inc    = (scnt_q == '1) ? scnt_q : scnt_q + CNT_W'(1);

   assign adc_rst_n_out    = (state_q == RUN);
   assign busy_out         = (state_q != IDLE);
   assign data_valid_out   = ~fifo_empty;
   assign overflow_out     = ovf_q;
   assign adc_config_1_out = cfg1_q;
   assign adc_config_2_out = cfg2_q;

   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      scnt_d  = scnt_q;
      burst_d = burst_q;
      cfg1_d  = cfg1_q;
      cfg2_d  = cfg2_q;
      ovf_d   = ovf_q;
      flush   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_in) begin
               cfg1_d  = cfg_1_in;
               cfg2_d  = cfg_2_in;
               burst_d = burst_len_in;
               flush   = 1'b1;
               ovf_d   = 1'b0;
               scnt_d  = '0;
               rcnt_d  = RC_W'(RST_CYCLES - 1);
               state_d = ADC_RST;
            end
         end
         ADC_RST: begin
            if (stop_in)              state_d = IDLE;
            else if (rcnt_q == '0)    state_d = RUN;
            else                      rcnt_d  = rcnt_q - RC_W'(1);
         end
         RUN: begin
            if (push) begin
               scnt_d = scnt_inc;
               if ((burst_q != '0) && (scnt_inc == burst_q)) state_d = IDLE;
            end
            if (stop_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (drop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rcnt_q  <= '0;
         scnt_q  <= '0;
         burst_q <= '0;
         cfg1_q  <= '0;
         cfg2_q  <= '0;
         ovf_q   <= 1'b0;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         scnt_q  <= scnt_d;
         burst_q <= burst_d;
         cfg1_q  <= cfg1_d;
         cfg2_q  <= cfg2_d;
         ovf_q   <= ovf_d;
         sync_q  <= {sync_q[1:0], adc_conv_finished_in};
      end
   end

   adc_result_fifo #(
      .WIDTH (ADC_DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush),
      .push_i     (push),
      .push_dat_i (adc_result_in),
      .pop_i      (pop),
      .head_dat_o (data_out),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .level_o    (fifo_level_out)
   );
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: table-driven burst run plus overflow, full push/pop, stop and reset sequences.
module tb_adc_capture_ctrl;
   logic        clk, rst;
   logic        start_in, stop_in;
   logic [15:0] burst_len_in;
   logic [9:0]  cfg_1_in, cfg_2_in;
   logic        adc_conv_finished_in;
   logic [9:0]  adc_result_in;
   logic        adc_rst_n_out;
   logic [9:0]  adc_config_1_out, adc_config_2_out, data_out;
   logic        data_valid_out, data_ready_in, busy_out, overflow_out;
   logic [3:0]  fifo_level_out;

   int errors = 0;
   int checks = 0;

   adc_capture_ctrl #(.FIFO_DEPTH(8), .RST_CYCLES(16), .CNT_W(16)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .start_in             (start_in),
      .stop_in              (stop_in),
      .burst_len_in         (burst_len_in),
      .cfg_1_in             (cfg_1_in),
      .cfg_2_in             (cfg_2_in),
      .adc_conv_finished_in (adc_conv_finished_in),
      .adc_result_in        (adc_result_in),
      .adc_rst_n_out        (adc_rst_n_out),
      .adc_config_1_out     (adc_config_1_out),
      .adc_config_2_out     (adc_config_2_out),
      .data_out             (data_out),
      .data_valid_out       (data_valid_out),
      .data_ready_in        (data_ready_in),
      .busy_out             (busy_out),
      .overflow_out         (overflow_out),
      .fifo_level_out       (fifo_level_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit       start, stop, conv;
      bit [9:0] res;
      bit       rdy;
      int       n;
      bit       e_rst_n, e_busy, e_vld;
      bit [9:0] e_dat;
      int       e_lvl;
      bit       e_ovf;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold the strobe high three edges (push on the third), then low two edges.
   task automatic strobe(input logic [9:0] res, input logic rdy_at_push);
      adc_conv_finished_in = 1'b1;
      adc_result_in        = res;
      data_ready_in        = 1'b0;
      step(2);
      data_ready_in = rdy_at_push;
      step(1);
      data_ready_in        = 1'b0;
      adc_conv_finished_in = 1'b0;
      step(2);
   endtask

   task automatic start_run(input logic [15:0] blen, input logic [9:0] c1, input logic [9:0] c2);
      burst_len_in = blen;
      cfg_1_in     = c1;
      cfg_2_in     = c2;
      start_in     = 1'b1;
      step(1);
      start_in = 1'b0;
      step(16);
   endtask

   logic [9:0] drain_exp [8];

   initial begin
      rst = 1'b1;
      start_in = 1'b0; stop_in = 1'b0; burst_len_in = '0;
      cfg_1_in = '0; cfg_2_in = '0;
      adc_conv_finished_in = 1'b0; adc_result_in = '0; data_ready_in = 1'b0;

      tbl[0]  = '{1'b1,1'b0,1'b0,10'h000,1'b0, 1, 1'b0,1'b1,1'b0,10'h000,0,1'b0};
      tbl[1]  = '{1'b0,1'b0,1'b0,10'h000,1'b0,14, 1'b0,1'b1,1'b0,10'h000,0,1'b0};
      tbl[2]  = '{1'b0,1'b0,1'b0,10'h000,1'b0, 1, 1'b0,1'b1,1'b0,10'h000,0,1'b0};
      tbl[3]  = '{1'b0,1'b0,1'b0,10'h000,1'b0, 1, 1'b1,1'b1,1'b0,10'h000,0,1'b0};
      tbl[4]  = '{1'b0,1'b0,1'b1,10'h001,1'b0, 1, 1'b1,1'b1,1'b0,10'h000,0,1'b0};
      tbl[5]  = '{1'b0,1'b0,1'b1,10'h001,1'b0, 1, 1'b1,1'b1,1'b0,10'h000,0,1'b0};
      tbl[6]  = '{1'b0,1'b0,1'b1,10'h001,1'b0, 1, 1'b1,1'b1,1'b1,10'h001,1,1'b0};
      tbl[7]  = '{1'b0,1'b0,1'b0,10'h001,1'b1, 2, 1'b1,1'b1,1'b0,10'h000,0,1'b0};
      tbl[8]  = '{1'b0,1'b0,1'b1,10'h3FF,1'b1, 2, 1'b1,1'b1,1'b0,10'h000,0,1'b0};
      tbl[9]  = '{1'b0,1'b0,1'b1,10'h3FF,1'b1, 1, 1'b1,1'b1,1'b1,10'h3FF,1,1'b0};
      tbl[10] = '{1'b0,1'b0,1'b0,10'h3FF,1'b1, 2, 1'b1,1'b1,1'b0,10'h000,0,1'b0};
      tbl[11] = '{1'b0,1'b0,1'b1,10'h200,1'b0, 3, 1'b0,1'b0,1'b1,10'h200,1,1'b0};
      tbl[12] = '{1'b0,1'b0,1'b0,10'h200,1'b1, 1, 1'b0,1'b0,1'b0,10'h000,0,1'b0};

      // Reset state
      step(2);
      chk("rst_adc_rst_n", int'(adc_rst_n_out), 0);
      chk("rst_busy", int'(busy_out), 0);
      chk("rst_valid", int'(data_valid_out), 0);
      chk("rst_level", int'(fifo_level_out), 0);
      chk("rst_ovf", int'(overflow_out), 0);
      chk("rst_data", int'(data_out), 0);
      chk("rst_cfg1", int'(adc_config_1_out), 0);
      chk("rst_cfg2", int'(adc_config_2_out), 0);
      rst = 1'b0;
      step(1);

      // Burst of three, table driven
      burst_len_in = 16'd3;
      cfg_1_in = 10'h0AB;
      cfg_2_in = 10'h155;
      for (int i = 0; i < 13; i++) begin
         start_in             = tbl[i].start;
         stop_in              = tbl[i].stop;
         adc_conv_finished_in = tbl[i].conv;
         adc_result_in        = tbl[i].res;
         data_ready_in        = tbl[i].rdy;
         step(tbl[i].n);
         start_in = 1'b0;
         stop_in  = 1'b0;
         chk($sformatf("v%0d_adc_rst_n", i), int'(adc_rst_n_out), int'(tbl[i].e_rst_n));
         chk($sformatf("v%0d_busy", i), int'(busy_out), int'(tbl[i].e_busy));
         chk($sformatf("v%0d_valid", i), int'(data_valid_out), int'(tbl[i].e_vld));
         chk($sformatf("v%0d_level", i), int'(fifo_level_out), tbl[i].e_lvl);
         chk($sformatf("v%0d_ovf", i), int'(overflow_out), int'(tbl[i].e_ovf));
         if (tbl[i].e_vld) chk($sformatf("v%0d_data", i), int'(data_out), int'(tbl[i].e_dat));
         if (i == 3) begin
            chk("burst_cfg1", int'(adc_config_1_out), 'h0AB);
            chk("burst_cfg2", int'(adc_config_2_out), 'h155);
         end
      end
      data_ready_in = 1'b0;
      chk("idle_cfg1_held", int'(adc_config_1_out), 'h0AB);

      // Continuous run overflowing an 8-deep FIFO
      start_run(16'd0, 10'h3C3, 10'h0F0);
      chk("ovf_cfg1", int'(adc_config_1_out), 'h3C3);
      chk("ovf_cfg2", int'(adc_config_2_out), 'h0F0);
      for (int i = 0; i < 10; i++) strobe(10'h010 + 10'(i), 1'b0);
      chk("ovf_level", int'(fifo_level_out), 8);
      chk("ovf_flag", int'(overflow_out), 1);
      chk("ovf_head", int'(data_out), 'h010);
      chk("ovf_busy", int'(busy_out), 1);
      stop_in = 1'b1;
      step(1);
      stop_in = 1'b0;
      chk("stop_busy", int'(busy_out), 0);
      chk("stop_keeps_level", int'(fifo_level_out), 8);

      // Restart flushes and clears overflow; then full with simultaneous push and pop
      start_in = 1'b1;
      step(1);
      start_in = 1'b0;
      chk("restart_level", int'(fifo_level_out), 0);
      chk("restart_ovf", int'(overflow_out), 0);
      chk("restart_valid", int'(data_valid_out), 0);
      step(16);
      for (int i = 0; i < 8; i++) strobe(10'h020 + 10'(i), 1'b0);
      chk("full_level", int'(fifo_level_out), 8);
      chk("full_ovf", int'(overflow_out), 0);
      strobe(10'h060, 1'b1);
      chk("pushpop_level", int'(fifo_level_out), 8);
      chk("pushpop_ovf", int'(overflow_out), 0);
      for (int i = 0; i < 7; i++) drain_exp[i] = 10'h021 + 10'(i);
      drain_exp[7] = 10'h060;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d_data", i), int'(data_out), int'(drain_exp[i]));
         data_ready_in = 1'b1;
         step(1);
      end
      data_ready_in = 1'b0;
      chk("drain_level", int'(fifo_level_out), 0);
      chk("drain_valid", int'(data_valid_out), 0);
      stop_in = 1'b1;
      step(1);
      stop_in = 1'b0;

      // Stop during the ADC reset phase
      burst_len_in = 16'd0;
      start_in = 1'b1;
      step(1);
      start_in = 1'b0;
      step(4);
      stop_in = 1'b1;
      step(1);
      stop_in = 1'b0;
      chk("rststop_busy", int'(busy_out), 0);
      chk("rststop_adc_rst_n", int'(adc_rst_n_out), 0);
      strobe(10'h2AA, 1'b0);
      chk("rststop_level", int'(fifo_level_out), 0);
      chk("rststop_valid", int'(data_valid_out), 0);
      chk("rststop_adc_rst_n2", int'(adc_rst_n_out), 0);

      // Asynchronous reset mid-run with four entries queued
      start_run(16'd0, 10'h111, 10'h222);
      for (int i = 0; i < 4; i++) strobe(10'h030 + 10'(i), 1'b0);
      chk("pre_rst_level", int'(fifo_level_out), 4);
      chk("pre_rst_adc_rst_n", int'(adc_rst_n_out), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_adc_rst_n", int'(adc_rst_n_out), 0);
      chk("arst_level", int'(fifo_level_out), 0);
      chk("arst_valid", int'(data_valid_out), 0);
      chk("arst_busy", int'(busy_out), 0);
      chk("arst_data", int'(data_out), 0);
      chk("arst_cfg1", int'(adc_config_1_out), 0);
      chk("arst_cfg2", int'(adc_config_2_out), 0);
      step(1);
      rst = 1'b0;
      step(2);
      chk("post_rst_busy", int'(busy_out), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Host-side reader for the ADC core digital interface.
- Sequences the ADC core's active-low reset and drives its two static 10-bit config words.
- Synchronizes the core's conversion-finished strobe, which arrives from the ADC's own clock domain.
- Captures each 10-bit result into a FIFO and delivers samples to the SoC over a valid/ready stream. Supports burst (N-sample) and continuous capture.

Parameters:
- FIFO_DEPTH, 8, result FIFO entries; power of two, 2..64.
- RST_CYCLES, 16, clk cycles the ADC reset is held low after start.
- CNT_W, 16, width of the burst length and sample counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start_in  in  1  one-cycle pulse; begins a capture run
- stop_in  in  1  one-cycle pulse; aborts the run
- burst_len_in  in  CNT_W  samples per run; 0 = continuous
- cfg_1_in  in  10  ADC config word 1, latched on start
- cfg_2_in  in  10  ADC config word 2, latched on start
- adc_conv_finished_in  in  1  conversion-done level/pulse from the ADC clock domain (asynchronous)
- adc_result_in  in  10  ADC result; stable ≥4 clk cycles after conv_finished rises
- adc_rst_n_out  out  1  ADC core reset, active low
- adc_config_1_out  out  10  latched config 1
- adc_config_2_out  out  10  latched config 2
- data_out  out  10  FIFO head sample
- data_valid_out  out  1  FIFO non-empty
- data_ready_in  in  1  consumer accepts data_out
- busy_out  out  1  state != IDLE
- overflow_out  out  1  sticky; a sample was dropped
- fifo_level_out  out  $clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset values:
  - adc_rst_n_out=0; config outputs=0; data_valid_out=0; overflow_out=0; fifo_level_out=0; busy_out=0.
  - data_out=0; FSM=IDLE; all counters=0; synchronizer flops=0.
- Clock and reset: single clock domain. Reset is asynchronous assert, synchronous deassert, handled outside this block.
- FSM states: IDLE, ADC_RST, RUN.
  - IDLE: adc_rst_n_out=0. On start_in: latch cfg_1/2 and burst_len; flush FIFO; clear overflow_out and the sample counter; load the reset counter with RST_CYCLES-1; go to ADC_RST.
  - ADC_RST: adc_rst_n_out=0; counter decrements; go to RUN when it reaches 0. The reset is low for exactly RST_CYCLES cycles. stop_in goes to IDLE.
  - RUN: adc_rst_n_out=1; config outputs stay constant.
    - Each detected strobe edge pushes adc_result_in and increments the sample counter.
    - If burst_len≠0 and the counter reaches burst_len on a push, go to IDLE next cycle.
    - stop_in goes to IDLE; a push in the same cycle as stop_in is still accepted.
  - start_in outside IDLE is ignored.
- Strobe synchronization:
  - 2-FF synchronizer followed by a third flop for rising-edge detect: edge = s2 & ~s3.
  - Edges are only acted on in RUN; the synchronizer keeps running in every state.
  - adc_result_in is sampled directly in the edge cycle; the ≥4-cycle stability contract makes this safe.
- Latency: if adc_conv_finished_in is sampled high at clock edge k, the push occurs at edge k+2 and data_valid_out is high after edge k+2 (FIFO previously empty).
- FIFO behaviour:
  - Push when edge & RUN. Pop when data_valid_out & data_ready_in.
  - Full and push without pop: the sample is dropped and overflow_out set. The dropped sample still counts toward the burst.
  - Full with push and pop in the same cycle: both are accepted; level unchanged.
  - Empty with push and pop: the pop is invalid (valid=0); the push is accepted.
  - data_out is the registered head entry, held stable while valid & ~ready.
- Return to IDLE does not flush the FIFO; the consumer may drain remaining samples. Only start_in flushes.
- Config outputs keep their last latched values in IDLE. Only rst clears them.
- Reset asserted mid-run: everything returns to reset values immediately; adc_rst_n_out goes low asynchronously.
- The sample counter saturates at its maximum value in continuous mode.

Decomposition:
- Package adc_capture_pkg holds:
  - the state enum (IDLE, ADC_RST, RUN, encoded in 2 bits);
  - ADC_DATA_W=10 and ADC_CFG_W=10.
- One natural sub-module: adc_result_fifo, a synchronous FIFO with push, pop, full, empty, level and flush; parameterized on width and depth.
- Synchronizer and FSM stay in the top level.

Test Plan:
- Reset then start with burst_len=3, cfg_1=0x0AB, cfg_2=0x155 → adc_rst_n_out low for 16 cycles then high; config outputs read 0x0AB and 0x155.
- Three strobes with results 0x001, 0x3FF, 0x200, consumer ready → three pops in that order; busy_out drops after the third push; data_valid_out high 3 edges after the first strobe.
- burst_len=0, ready=0, 10 strobes with FIFO_DEPTH=8 → fifo_level_out=8, overflow_out=1, head=first sample. The next start clears the overflow flag and flushes the FIFO.
- FIFO full, ready=1, strobe pushing in the same cycle as a pop → level stays 8; no overflow; ordering preserved.
- stop_in pulsed during ADC_RST → IDLE immediately; adc_rst_n_out stays 0; a later strobe produces no push.
- Assert rst mid-RUN with 4 entries queued → all outputs at reset values; fifo_level_out=0; adc_rst_n_out=0 without waiting for a clock edge.
